// File: rtl/shift_seq.sv
// shift_seq: multi-cycle SLL/SRL/SRA/ROR shifter, up to STEP bits per cycle, valid/ready on both sides.
// Build option: define SHIFT_SEQ_ROTATE_EN to enable ROR for mode 11; otherwise mode 11 runs as SLL.
module shift_seq #(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [$clog2(N)-1:0] in_shamt,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 busy
);
  localparam int SW = $clog2(N);
  localparam int KW = $clog2(STEP) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state;
  logic [N-1:0]  work, stepped, sll, srl, sra;
  logic [SW-1:0] rem;
  logic [1:0]    mode;
  logic [KW-1:0] k;
  logic          gt;
  assign in_ready = state == IDLE;
  assign out_data = work;
  assign gt = {1'b0, rem} > (SW+1)'(STEP);
  assign k = gt ? KW'(STEP) : KW'(rem);
  assign sll = work << k;
  assign srl = work >> k;
  assign sra = $signed(work) >>> k;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic [N-1:0] ror;
  assign ror = N'({work, work} >> k);
  always_comb stepped = mode == 2'b00 ? sll : mode == 2'b01 ? srl : mode == 2'b10 ? sra : ror;
`else
  always_comb stepped = mode[1] ? sra : mode[0] ? srl : sll;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      rem       <= '0;
      mode      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work  <= in_data;
          rem   <= in_shamt;
`ifdef SHIFT_SEQ_ROTATE_EN
          mode  <= in_mode;
`else
          mode  <= in_mode == 2'b11 ? 2'b00 : in_mode;
`endif
          state <= BUSY;
          busy  <= 1'b1;
        end
        BUSY: begin
          work <= stepped;
          if (gt) rem <= rem - SW'(STEP);
          else begin
            rem       <= '0;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed plus randomized checks of shift_seq against an arithmetic reference model.
module tb_shift_seq;
  localparam int N = 32;
  localparam int STEP = 4;
  logic          clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic          in_ready, out_valid, busy;
  logic [N-1:0]  in_data = '0, out_data;
  logic [4:0]    in_shamt = '0;
  logic [1:0]    in_mode = '0;
  int            checks = 0, errors = 0;

  shift_seq #(.N(N), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic [1:0] m);
    logic [63:0] dd;
    dd = {d, d} >> s;
    case (m)
      2'b00: return d << s;
      2'b01: return d >> s;
      2'b10: return $signed(d) >>> s;
`ifdef SHIFT_SEQ_ROTATE_EN
      default: return dd[31:0];
`else
      default: return d << s;
`endif
    endcase
  endfunction

  // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run_op(input logic [31:0] d, input int s, input logic [1:0] m, input int hold,
                        input logic [31:0] exp);
    int cnt, t, exp_cyc;
    logic [31:0] held;
    exp_cyc = s == 0 ? 1 : (s + STEP - 1) / STEP;
    chk("idle_ready", in_ready, 1);
    in_valid = 1; in_data = d; in_shamt = 5'(s); in_mode = m;
    @(negedge clk);
    in_valid = 0; in_data = $urandom; in_shamt = 5'($urandom); in_mode = 2'($urandom);
    cnt = 0; t = 0;
    while (!out_valid && t < 100) begin
      if (busy) cnt++;
      t++;
      @(negedge clk);
    end
    chk("busy_cycles", cnt, exp_cyc);
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp);
    chk("done_not_busy", busy, 0);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; in_data = $urandom;
      @(negedge clk);
      chk("bp_data", out_data, held);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("handoff_ready", in_ready, 1);
    chk("handoff_valid", out_valid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    run_op(32'h0000_0001, 31, 2'b00, 0, 32'h8000_0000);
    run_op(32'h8000_0000, 4, 2'b10, 0, 32'hF800_0000);
    run_op(32'h8000_0000, 4, 2'b01, 0, 32'h0800_0000);
    run_op(32'hDEAD_BEEF, 0, 2'b00, 0, 32'hDEAD_BEEF);
`ifdef SHIFT_SEQ_ROTATE_EN
    run_op(32'h0000_0001, 1, 2'b11, 0, 32'h8000_0000);
    run_op(32'h1234_5678, 8, 2'b11, 0, 32'h7812_3456);
`else
    run_op(32'h0000_0001, 1, 2'b11, 0, 32'h0000_0002);
`endif
    run_op(32'h8765_4321, 13, 2'b10, 5, model(32'h8765_4321, 13, 2'b10));
    // reset lands on the third BUSY cycle of a long shift
    in_valid = 1; in_data = 32'h1; in_shamt = 5'd31; in_mode = 2'b00;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    run_op(32'h0000_00F0, 4, 2'b01, 0, 32'h0000_000F);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] d;
      int s;
      logic [1:0] m;
      d = $urandom;
      s = $urandom_range(0, N - 1);
      m = 2'($urandom);
      run_op(d, s, m, $urandom_range(0, 3), model(d, s, m));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
